// File: rtl/sram_load_check_seq.sv
// SRAM load-and-verify sequencer: streams words into one of NCH SRAMs, reads them
// back against an expected stream and reports mismatch count and first failing address.
module sram_load_check_seq #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 7,
  parameter  int NCH    = 2,
  parameter  int ERR_W  = 16,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [1:0]              cmd_mode,
  input  logic [ADDR_W-1:0]       cmd_base,
  input  logic [ADDR_W:0]         cmd_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NCH-1:0]          sram_cen,
  output logic                    sram_wen,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_d,
  input  logic [NCH*DATA_W-1:0]   sram_q,
  output logic                    busy,
  output logic                    done,
  output logic                    cmd_err,
  output logic                    err_flag,
  output logic [ERR_W-1:0]        err_cnt,
  output logic [ADDR_W-1:0]       first_err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_CHECK = 2'b01;
  localparam logic [1:0] MODE_LTC   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  state_t              r_state, w_next;
  logic [CH_W-1:0]     r_ch;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_k;
  logic                r_cmpValid;
  logic [DATA_W-1:0]   r_cmpData;
  logic [ADDR_W-1:0]   r_cmpAddr;
  logic [ADDR_W-1:0]   r_addrHold;
  logic [DATA_W-1:0]   r_dHold;
  logic                r_errFlag;
  logic                r_cmdErr;
  logic [ERR_W-1:0]    r_errCnt;
  logic [ADDR_W-1:0]   r_firstErr;

  logic                w_accept;
  logic                w_beat;
  logic                w_last;
  logic                w_chIllegal;
  logic [31:0]         w_chWide;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_q;
  logic                w_mismatch;
  logic                w_access;
  logic                w_write;

  assign w_chWide    = 32'(cmd_ch);
  assign w_chIllegal = (w_chWide >= NCH);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_beat      = in_valid && in_ready;
  assign w_last      = (r_k == r_len - (ADDR_W+1)'(1));
  // Truncating k to ADDR_W bits makes base+k wrap around the SRAM naturally.
  assign w_addr      = r_base + r_k[ADDR_W-1:0];
  assign w_mismatch  = r_cmpValid && (w_q != r_cmpData);

  always_comb begin
    w_q = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_ch == CH_W'(c)) w_q = sram_q[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    w_access  = 1'b0;
    w_write   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_len == '0 || cmd_mode == MODE_RSVD || w_chIllegal) w_next = S_DONE;
          else if (cmd_mode == MODE_CHECK)                           w_next = S_CHECK;
          else                                                       w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_access = 1'b1;
          w_write  = 1'b1;
          if (w_last) w_next = (r_mode == MODE_LTC) ? S_CHECK : S_DONE;
        end
      end
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_access = 1'b1;
          if (w_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_cen = '1;
    for (int c = 0; c < NCH; c++) begin
      if (w_access && r_ch == CH_W'(c)) sram_cen[c] = 1'b0;
    end
  end

  assign sram_wen  = ~w_write;
  assign sram_addr = w_access ? w_addr : r_addrHold;
  assign sram_d    = w_write ? in_data : r_dHold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_mode     <= MODE_LOAD;
      r_base     <= '0;
      r_len      <= '0;
      r_k        <= '0;
      r_cmpValid <= 1'b0;
      r_cmpData  <= '0;
      r_cmpAddr  <= '0;
      r_addrHold <= '0;
      r_dHold    <= '0;
      r_errFlag  <= 1'b0;
      r_cmdErr   <= 1'b0;
      r_errCnt   <= '0;
      r_firstErr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ch       <= cmd_ch;
        r_mode     <= cmd_mode;
        r_base     <= cmd_base;
        r_len      <= cmd_len;
        r_k        <= '0;
        r_cmpValid <= 1'b0;
        r_errFlag  <= 1'b0;
        r_errCnt   <= '0;
        r_firstErr <= '0;
        r_cmdErr   <= (cmd_mode == MODE_RSVD) || w_chIllegal;
      end else begin
        // The last load beat rewinds k so a following check starts at base again.
        if (w_beat) r_k <= w_last ? '0 : r_k + (ADDR_W+1)'(1);
        r_cmpValid <= w_beat && (r_state == S_CHECK);
        if (w_beat && r_state == S_CHECK) begin
          r_cmpData <= in_data;
          r_cmpAddr <= w_addr;
        end
        if (w_mismatch) begin
          if (r_errCnt != '1) r_errCnt <= r_errCnt + ERR_W'(1);
          r_errFlag <= 1'b1;
          if (!r_errFlag) r_firstErr <= r_cmpAddr;
        end
      end
      if (w_access) begin
        r_addrHold <= w_addr;
        if (w_write) r_dHold <= in_data;
      end
    end
  end

  assign cmd_err        = r_cmdErr;
  assign err_flag       = r_errFlag;
  assign err_cnt        = r_errCnt;
  assign first_err_addr = r_firstErr;

endmodule

// File: tb/tb_sram_load_check_seq.sv
// Scoreboard bench for sram_load_check_seq: commands push expected completion results,
// a monitor pops and compares them whenever done pulses; a behavioural SRAM sits on the ports.
module tb_sram_load_check_seq;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int NCH    = 3;
  localparam int ERR_W  = 4;
  localparam int CH_W   = 2;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CH_W-1:0]       cmd_ch;
  logic [1:0]            cmd_mode;
  logic [ADDR_W-1:0]     cmd_base;
  logic [LEN_W-1:0]      cmd_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [NCH-1:0]        sram_cen;
  logic                  sram_wen;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_d;
  logic [NCH*DATA_W-1:0] sram_q;
  logic                  busy;
  logic                  done;
  logic                  cmd_err;
  logic                  err_flag;
  logic [ERR_W-1:0]      err_cnt;
  logic [ADDR_W-1:0]     first_err_addr;

  sram_load_check_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .sram_q(sram_q),
    .busy(busy), .done(done), .cmd_err(cmd_err), .err_flag(err_flag),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Behavioural SRAMs with per-address access counters
  logic [DATA_W-1:0] mem  [NCH][DEPTH];
  logic [DATA_W-1:0] qReg [NCH];
  int wrCnt  [NCH][DEPTH];
  int rdCnt  [NCH][DEPTH];
  int wrSnap [NCH][DEPTH];
  int rdSnap [NCH][DEPTH];
  int accessTotal = 0;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!sram_cen[c]) begin
        if (!sram_wen) begin
          mem[c][sram_addr]   <= sram_d;
          wrCnt[c][sram_addr] <= wrCnt[c][sram_addr] + 1;
        end else begin
          qReg[c]             <= mem[c][sram_addr];
          rdCnt[c][sram_addr] <= rdCnt[c][sram_addr] + 1;
        end
        accessTotal <= accessTotal + 1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) sram_q[c*DATA_W +: DATA_W] = qReg[c];
  end

  int cycleCnt   = 0;
  int acceptEdge = 0;
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (!reset && cmd_valid && cmd_ready) acceptEdge <= cycleCnt;
  end

  typedef struct {
    string name;
    int    latency;
    int    errCnt;
    int    errFlag;
    int    firstAddr;
    int    cmdErr;
  } exp_t;

  exp_t expQ[$];
  int errors   = 0;
  int checks   = 0;
  int doneSeen = 0;

  logic [DATA_W-1:0] stream[$];
  bit                validPat[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse retires one expected completion
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      doneSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.name, " latency"},        cycleCnt - acceptEdge, e.latency);
        checkOutput({e.name, " err_cnt"},        int'(err_cnt),         e.errCnt);
        checkOutput({e.name, " err_flag"},       int'(err_flag),        e.errFlag);
        checkOutput({e.name, " first_err_addr"}, int'(first_err_addr),  e.firstAddr);
        checkOutput({e.name, " cmd_err"},        int'(cmd_err),         e.cmdErr);
      end
    end
  end

  function automatic logic [DATA_W-1:0] mkWord(input int tag, input int i);
    return (32'(tag) << 24) | 32'(i * 1103 + 7);
  endfunction

  task automatic takeSnap();
    wrSnap = wrCnt;
    rdSnap = rdCnt;
  endtask

  task automatic checkCounts(input string name, input int ch, input int base, input int len,
                             input int expWr, input int expRd);
    int badWr;
    int badRd;
    bit inRange;
    badWr = 0;
    badRd = 0;
    for (int a = 0; a < DEPTH; a++) begin
      inRange = ((a - base + DEPTH) % DEPTH) < len;
      if (wrCnt[ch][a] - wrSnap[ch][a] != (inRange ? expWr : 0)) badWr++;
      if (rdCnt[ch][a] - rdSnap[ch][a] != (inRange ? expRd : 0)) badRd++;
    end
    checkOutput({name, " addrs with wrong write count"}, badWr, 0);
    checkOutput({name, " addrs with wrong read count"},  badRd, 0);
  endtask

  // Issues one command from an idle DUT, streams `stream` gated by `validPat`, waits for done
  task automatic applyStimulus(input string name, input int ch, input int mode, input int base,
                               input int len, input int baseLat, input int expCnt,
                               input int expFlag, input int expFirst, input int expCmdErr);
    exp_t e;
    int   ones, stalls, p, idx, guard, startDone;
    bit   v, rdy;
    ones   = 0;
    stalls = 0;
    p      = 0;
    while (ones < stream.size()) begin
      v = (p < validPat.size()) ? validPat[p] : 1'b1;
      if (v) ones++;
      else   stalls++;
      p++;
    end
    e.name      = name;
    e.latency   = baseLat + stalls;
    e.errCnt    = expCnt;
    e.errFlag   = expFlag;
    e.firstAddr = expFirst;
    e.cmdErr    = expCmdErr;
    expQ.push_back(e);
    startDone = doneSeen;

    cmd_ch    = CH_W'(ch);
    cmd_mode  = 2'(mode);
    cmd_base  = ADDR_W'(base);
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    idx   = 0;
    p     = 0;
    guard = 0;
    while (idx < stream.size() && guard < 2000) begin
      in_valid = (p < validPat.size()) ? validPat[p] : 1'b1;
      in_data  = stream[idx];
      p++;
      guard++;
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      #1;
    end
    in_valid = 1'b0;
    if (idx < stream.size()) checkOutput({name, " stream timeout"}, idx, stream.size());

    guard = 0;
    while (doneSeen == startDone && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (doneSeen == startDone) checkOutput({name, " done timeout"}, 0, 1);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snapDone;
    int snapAccess;
    logic [DATA_W-1:0] w;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_mode  = '0;
    cmd_base  = '0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("reset cmd_ready",      int'(cmd_ready),      1);
    checkOutput("reset busy",           int'(busy),           0);
    checkOutput("reset done",           int'(done),           0);
    checkOutput("reset in_ready",       int'(in_ready),       0);
    checkOutput("reset sram_cen",       int'(sram_cen),       7);
    checkOutput("reset sram_wen",       int'(sram_wen),       1);
    checkOutput("reset sram_addr",      int'(sram_addr),      0);
    checkOutput("reset sram_d",         int'(sram_d),         0);
    checkOutput("reset err_cnt",        int'(err_cnt),        0);
    checkOutput("reset err_flag",       int'(err_flag),       0);
    checkOutput("reset cmd_err",        int'(cmd_err),        0);
    checkOutput("reset first_err_addr", int'(first_err_addr), 0);
    @(posedge clk); #1;

    // Load 72 words into ch0 at 0..71: writes 1..72, done in cycle 73
    stream = {};
    validPat = {};
    for (int i = 0; i < 72; i++) stream.push_back(mkWord(8'hA5, i));
    takeSnap();
    applyStimulus("load72", 0, 0, 0, 72, 73, 0, 0, 0, 0);
    checkCounts("load72", 0, 0, 72, 1, 0);

    // Check the same 72 words: done in cycle 74, clean
    takeSnap();
    applyStimulus("check72", 0, 1, 0, 72, 74, 0, 0, 0, 0);
    checkCounts("check72", 0, 0, 72, 0, 1);

    // Load-then-check across the wrap: 120..127 then 0..7, done in cycle 34
    stream = {};
    for (int i = 0; i < 16; i++) stream.push_back(mkWord(8'h3C, i));
    for (int i = 0; i < 16; i++) stream.push_back(mkWord(8'h3C, i));
    takeSnap();
    applyStimulus("ltc16 wrap", 1, 2, 120, 16, 34, 0, 0, 0, 0);
    checkCounts("ltc16 wrap", 1, 120, 16, 1, 1);

    // Check 36 words from base 10 with expected words 5 and 9 corrupted
    stream = {};
    for (int i = 0; i < 36; i++) begin
      w = mkWord(8'hA5, 10 + i);
      if (i == 5 || i == 9) w = w ^ 32'h0000_0100;
      stream.push_back(w);
    end
    applyStimulus("check36 corrupt", 0, 1, 10, 36, 38, 2, 1, 15, 0);

    // Load-then-check len 36 on ch2 with ~30% in_valid stalls
    stream = {};
    for (int i = 0; i < 36; i++) stream.push_back(mkWord(8'h5A, i));
    for (int i = 0; i < 36; i++) stream.push_back(mkWord(8'h5A, i));
    validPat = {};
    for (int i = 0; i < 200; i++) validPat.push_back($urandom_range(0, 99) >= 30);
    takeSnap();
    applyStimulus("ltc36 stalls", 2, 2, 50, 36, 74, 0, 0, 0, 0);
    checkCounts("ltc36 stalls", 2, 50, 36, 1, 1);
    validPat = {};

    // Degenerate commands: done in cycle 1 with no SRAM access
    stream = {};
    snapAccess = accessTotal;
    applyStimulus("mode11", 0, 3, 0, 4, 1, 0, 0, 0, 1);
    applyStimulus("len0",   1, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("ch=NCH", 3, 0, 0, 4, 1, 0, 0, 0, 1);
    checkOutput("degenerate cmds SRAM accesses", accessTotal - snapAccess, 0);

    // Reset in cycle 10 of a len-72 load on ch1 base 40
    snapDone  = doneSeen;
    cmd_ch    = 2'd1;
    cmd_mode  = 2'b00;
    cmd_base  = 7'd40;
    cmd_len   = 8'd72;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = mkWord(8'h77, i);
      @(posedge clk); #1;
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after reset sram_cen",  int'(sram_cen),  7);
    checkOutput("after reset sram_wen",  int'(sram_wen),  1);
    checkOutput("after reset busy",      int'(busy),      0);
    checkOutput("after reset cmd_ready", int'(cmd_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("done pulses after abort", doneSeen - snapDone, 0);

    stream = {};
    for (int i = 0; i < 8; i++) stream.push_back(mkWord(8'h11, i));
    applyStimulus("post-reset load8", 1, 0, 3, 8, 9, 0, 0, 0, 0);

    // 20 mismatches against ch0 0..19: a 4-bit counter saturates at 15
    stream = {};
    for (int i = 0; i < 20; i++) stream.push_back(~mkWord(8'hA5, i));
    applyStimulus("saturate20", 0, 1, 0, 20, 22, 15, 1, 0, 0);

    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_load_check_seq.md
# sram_load_check_seq

Parametrised SRAM load-and-verify sequencer: streams words into one of NCH on-chip SRAMs (weight, activation, output banks), reads them back against an expected stream, and reports mismatch count and first failing address. It sits between the host/DMA stream and the core's SRAM ports as the hardware replacement for bench-driven SRAM load/check. It supports per-command channel, base address, length and mode.

## Interface
Parameters:
- DATA_W, 32, SRAM word width
- ADDR_W, 7, SRAM address width; addresses wrap modulo 2^ADDR_W
- NCH, 2, number of target SRAMs; CH_W = max(1, clog2(NCH))
- ERR_W, 16, error counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_ch  in  CH_W  target SRAM index; values >= NCH are illegal
- cmd_mode  in  2  00 load, 01 check, 10 load-then-check, 11 reserved
- cmd_base  in  ADDR_W  start address
- cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W
- in_valid / in_ready  in / out  1  data stream handshake (write data in load phase, expected data in check phase)
- in_data  in  DATA_W  stream word
- sram_cen  out  NCH  active-low chip enable, one-hot-low per channel
- sram_wen  out  1  active-low write enable, shared
- sram_addr  out  ADDR_W  shared address
- sram_d  out  DATA_W  shared write data
- sram_q  in  NCH*DATA_W  read data, channel c at [c*DATA_W +: DATA_W], valid the cycle after a read access
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at command completion
- cmd_err  out  1  reserved mode or illegal channel on last command
- err_flag  out  1  at least one mismatch on last command
- err_cnt  out  ERR_W  mismatch count, saturating at 2^ERR_W-1
- first_err_addr  out  ADDR_W  address of first mismatch

## Operation
- FSM: IDLE, LOAD, CHECK, DRAIN, DONE.
- IDLE: cmd_ready=1. Command acceptance (cmd_valid&cmd_ready) latches ch/mode/base/len and clears err_cnt, err_flag, first_err_addr and cmd_err. The index counter k resets to 0.
- Next state after accept:
  - cmd_len=0, mode 11 or cmd_ch>=NCH: DONE. cmd_err=1 for the mode/channel cases; no SRAM access.
  - mode 00/10: LOAD.
  - mode 01: CHECK.
- LOAD: in_ready=1. Each in_valid&in_ready beat drives cen[ch]=0, wen=0, addr=base+k, d=in_data, then increments k. With in_valid low, all cen=1 (bubble).
  - On the last beat (k=len-1): mode 10 goes to CHECK with k=0; mode 00 goes to DONE.
- CHECK: in_ready=1. Each beat issues a read (cen[ch]=0, wen=1, addr=base+k) and registers in_data and the address into a 1-deep compare stage.
  - Next cycle: the compare stage checks sram_q[ch] against the registered data. A mismatch increments err_cnt (saturating) and sets err_flag. If err_flag was clear, it also captures first_err_addr.
  - On the last beat, go to DRAIN.
- DRAIN: no access, in_ready=0; the final compare completes. Go to DONE.
- DONE: done=1 for one cycle, in_ready=0. Go to IDLE.
- Result outputs hold until the next command accept.
- Idle SRAM outputs: cen all 1, wen 1; addr/d hold their last value.

## Timing
- Reset values: state IDLE, cmd_ready 1, busy 0, done 0, in_ready 0, sram_cen all 1, sram_wen 1, sram_addr 0, sram_d 0, err_cnt 0, err_flag 0, cmd_err 0, first_err_addr 0, k 0.
- Reset mid-command: abort. No SRAM access in the cycle after the reset edge, no done pulse.
- Latency, accept at edge 0 with in_valid continuously high:
  - load: writes in cycles 1..N, done in cycle N+1, cmd_ready in N+2.
  - check: reads 1..N, compares 2..N+1, done N+2.
  - load-then-check: writes 1..N, reads N+1..2N, done 2N+2.
- Each in_valid stall cycle adds exactly one cycle.
- Address wrap: base+k is computed modulo 2^ADDR_W; a command with len=2^ADDR_W touches every address once.
- cmd_valid while busy is ignored and not accepted.
- err_cnt reflects a compare in the cycle after the read; it is final when done is high.

## Test plan
- Load 72 words, ch0, base 0, continuous valid → 72 writes at addr 0..71, done in cycle 73; check of the same 72 words → err_cnt=0, err_flag=0, done in cycle 74.
- Load-then-check, ch1, base 120, len 16 → writes at addr 120..127 then 0..7, reads in the same order; done in cycle 34, err_cnt=0.
- Check 36 words with expected words 5 and 9 corrupted → err_cnt=2, err_flag=1, first_err_addr=base+5.
- Random in_valid deassertion, 30% of cycles, during load-then-check len 36 → cycle count equals 74 plus stall count; every address written and read exactly once; err_cnt=0.
- Mode 11, len 0, and cmd_ch=NCH → done in cycle 1, no cen low; cmd_err=1 for mode 11 and cmd_ch=NCH, 0 for len 0.
- Reset asserted in cycle 10 of a len-72 load → next cycle: cen all 1, busy 0, done never pulses, cmd_ready 1; a new command then completes normally.
- ERR_W=4 with 20 mismatches → err_cnt saturates at 15.
